add_pipe_stage: RTL and testbench
=================================

Name: add_pipe_stage

Overview:
- Datapath stage that consumes the 4-bit a/b operand bus driven by the input agent and produces registered sums for the output agent.
- Adds a valid/ready handshake on both sides and a two-stage path: an add register followed by a result FIFO.
- Keeps a wrapping transaction counter and a saturating carry counter for scoreboard cross-checks.

Parameters:
- DATA_WIDTH, 4, operand width of a and b.
- FIFO_DEPTH, 4, result FIFO entries; must be a power of 2 and at least 2.
- CNT_WIDTH, 8, width of txn_count and carry_count.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands a/b are valid.
- in_ready  output  1  stage can accept operands this cycle.
- a  input  DATA_WIDTH  operand A.
- b  input  DATA_WIDTH  operand B.
- out_valid  output  1  sum holds valid data.
- out_ready  input  1  downstream accepts sum this cycle.
- sum  output  DATA_WIDTH+1  a+b; MSB is the carry.
- txn_count  output  CNT_WIDTH  count of accepted input transactions; wraps.
- carry_count  output  CNT_WIDTH  count of results with carry set; saturates at all-ones.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async assert, sync deassert by the environment):
  - s1_valid=0, FIFO empty, fifo_level=0, out_valid=0, sum=0.
  - txn_count=0, carry_count=0, in_ready=0 while reset is high.
- Reset mid-operation: all in-flight and buffered results are discarded; no partial output after release.
- Accept: input handshake = in_valid && in_ready, sampled on the rising edge.
- in_ready = !reset && (fifo_level + s1_valid < FIFO_DEPTH). It is combinational from registered state only, never from in_valid or out_ready.
- Stage 1 (add register):
  - On accept, s1_sum <= zero-extended a + zero-extended b (DATA_WIDTH+1 bits, no truncation); s1_valid <= 1.
  - Otherwise s1_valid <= 0 after its entry moves to the FIFO.
- Stage 2: whenever s1_valid=1, s1_sum is written into the FIFO on the next edge. There is always room, guaranteed by the in_ready rule.
- Output: out_valid = (fifo_level != 0). sum = FIFO head, shown first-word-fall-through.
- Output handshake = out_valid && out_ready. On that edge the head is popped.
- Holding rules:
  - sum and out_valid must hold stable while out_valid=1 and out_ready=0.
  - out_ready=1 with an empty FIFO has no effect.
- Latency:
  - Operands accepted at edge N: s1 loaded at N, FIFO write at N+1, out_valid high after edge N+1 (2-cycle latency into an empty FIFO).
  - Sustained throughput is 1 result per cycle when out_ready stays 1.
- Simultaneous FIFO write and pop in the same edge: fifo_level is unchanged and ordering is preserved.
- Full: the FIFO at FIFO_DEPTH, or at FIFO_DEPTH-1 with s1 occupied, forces in_ready=0. Operands presented then are not accepted and not counted.
- Pointers: read and write pointers wrap modulo FIFO_DEPTH. Full and empty are told apart using fifo_level, not pointer equality.
- Counters:
  - txn_count increments by 1 per input handshake and wraps from all-ones to 0.
  - carry_count increments when a value with MSB=1 is written into the FIFO; it holds at all-ones.
- Ordering: results leave strictly in acceptance order. No drops, no duplicates.

Test Plan:
- Single transaction: reset, then one handshake a=4'hF, b=4'h1, with out_ready=1. Required: out_valid rises exactly 2 cycles after accept with sum=5'h10; carry_count=1, txn_count=1.
- Back-to-back: 16 consecutive handshakes a=i, b=15-i, with out_ready=1 throughout. Required: every result is 5'h0F in order, in_ready stays 1, fifo_level ≤1, txn_count=16, carry_count=0.
- Backpressure full: out_ready=0, in_valid held high with a=b=4'h8.
  - Required: exactly 4 accepts (FIFO_DEPTH) and then in_ready=0; fifo_level=4; sum=5'h10 held stable.
  - Then out_ready=1: 4 pops in order, carry_count=4, and in_ready returns to 1.
- Simultaneous push/pop: FIFO at level 2, in_valid=1 and out_ready=1 for 10 cycles. Required: fifo_level stays 2 and the output sequence matches the input order.
- Counter boundaries:
  - 256 accepts: txn_count wraps to 0.
  - 300 carry-producing results: carry_count saturates at 8'hFF.
- Reset mid-stream: assert reset with 3 results buffered and s1 valid. Required: out_valid=0 immediately (asynchronously), all counters 0, and no stale sum emitted after release.

Source files
------------

// File: rtl/add_pipe_stage.sv
// Two-stage adder: an add register feeds a first-word-fall-through result FIFO,
// with valid/ready on both sides plus transaction and carry counters.
module add_pipe_stage #(
  parameter int DATA_WIDTH = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_WIDTH-1:0]         a,
  input  logic [DATA_WIDTH-1:0]         b,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH:0]           sum,
  output logic [CNT_WIDTH-1:0]          txn_count,
  output logic [CNT_WIDTH-1:0]          carry_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int SUM_W = DATA_WIDTH + 1;

  logic                 s1_valid_q, s1_valid_d;
  logic [SUM_W-1:0]     s1_sum_q, s1_sum_d;
  logic [SUM_W-1:0]     mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]     level_q, level_d;
  logic [LVL_W-1:0]     occ_s;
  logic [CNT_WIDTH-1:0] txn_q, txn_d;
  logic [CNT_WIDTH-1:0] carry_q, carry_d;
  logic                 accept_s, push_s, pop_s;

  // Occupancy counts the add register so a full FIFO never sees a write it cannot hold.
  assign occ_s      = level_q + LVL_W'(s1_valid_q);
  assign in_ready   = !reset && (occ_s < LVL_W'(FIFO_DEPTH));
  assign out_valid  = (level_q != {LVL_W{1'b0}});
  assign sum        = out_valid ? mem_q[rd_ptr_q] : {SUM_W{1'b0}};
  assign accept_s   = in_valid && in_ready;
  assign push_s     = s1_valid_q;
  assign pop_s      = out_valid && out_ready;

  assign txn_count   = txn_q;
  assign carry_count = carry_q;
  assign fifo_level  = level_q;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sum_d   = s1_sum_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    txn_d      = txn_q;
    carry_d    = carry_q;

    if (accept_s) begin
      s1_valid_d = 1'b1;
      s1_sum_d   = SUM_W'(a) + SUM_W'(b);
      txn_d      = txn_q + CNT_WIDTH'(1);
    end else begin
      s1_valid_d = 1'b0;
      s1_sum_d   = s1_sum_q;
      txn_d      = txn_q;
    end

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    if (push_s && s1_sum_q[SUM_W-1] && (carry_q != {CNT_WIDTH{1'b1}})) begin
      carry_d = carry_q + CNT_WIDTH'(1);
    end else begin
      carry_d = carry_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_sum_q   <= {SUM_W{1'b0}};
      wr_ptr_q   <= {PTR_W{1'b0}};
      rd_ptr_q   <= {PTR_W{1'b0}};
      level_q    <= {LVL_W{1'b0}};
      txn_q      <= {CNT_WIDTH{1'b0}};
      carry_q    <= {CNT_WIDTH{1'b0}};
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= {SUM_W{1'b0}};
      end
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_sum_q   <= s1_sum_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      txn_q      <= txn_d;
      carry_q    <= carry_d;
      if (push_s) begin
        mem_q[wr_ptr_q] <= s1_sum_q;
      end
    end
  end

endmodule

// File: tb/tb_add_pipe_stage.sv
// Directed bench for add_pipe_stage: table of single transactions plus
// hand-written streaming, backpressure, counter-boundary and reset sequences.
module tb_add_pipe_stage;

  logic       clock;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a;
  logic [3:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] sum;
  logic [7:0] txn_count;
  logic [7:0] carry_count;
  logic [2:0] fifo_level;

  int checks = 0;
  int errors = 0;
  int acc_cnt = 0;
  int n_carry = 0;
  logic [4:0] q [$];

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [4:0] exp_sum;
  } vec_t;

  vec_t tbl [8];

  add_pipe_stage #(.DATA_WIDTH(4), .FIFO_DEPTH(4), .CNT_WIDTH(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .sum         (sum),
    .txn_count   (txn_count),
    .carry_count (carry_count),
    .fifo_level  (fifo_level)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: drive at negedge, score handshakes, then settle just after the rising edge.
  task automatic cycle(input logic iv, input logic [3:0] aa, input logic [3:0] bb, input logic ordy);
    logic [4:0] e;
    @(negedge clock);
    in_valid = iv; a = aa; b = bb; out_ready = ordy;
    #1;
    if (out_valid && ordy) begin
      if (q.size() == 0) begin
        check("spurious_out", 32'(out_valid), 32'd0);
      end else begin
        e = q.pop_front();
        check("out_sum", 32'(sum), 32'(e));
      end
    end
    if (iv && in_ready) begin
      q.push_back({1'b0, aa} + {1'b0, bb});
      acc_cnt++;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && q.size() != 0; k++) cycle(1'b0, 4'h0, 4'h0, 1'b1);
    check("drain_empty", 32'(q.size()), 32'd0);
    check("drain_out_valid", 32'(out_valid), 32'd0);
  endtask

  task automatic reset_dut();
    @(negedge clock);
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = 4'h0; b = 4'h0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_txn", 32'(txn_count), 32'd0);
    check("rst_carry", 32'(carry_count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    q.delete();
    acc_cnt = 0;
    #1;
    check("rel_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    tbl[0] = '{4'hF, 4'h1, 5'h10};
    tbl[1] = '{4'h0, 4'h0, 5'h00};
    tbl[2] = '{4'h7, 4'h8, 5'h0F};
    tbl[3] = '{4'hF, 4'hF, 5'h1E};
    tbl[4] = '{4'h8, 4'h8, 5'h10};
    tbl[5] = '{4'h1, 4'h2, 5'h03};
    tbl[6] = '{4'hA, 4'h5, 5'h0F};
    tbl[7] = '{4'hC, 4'h9, 5'h15};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = 4'h0; b = 4'h0;
    reset_dut();

    // Single transactions: out_valid must rise exactly two edges after accept.
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      in_valid = 1'b1; a = tbl[i].a; b = tbl[i].b; out_ready = 1'b1;
      #1;
      check("tbl_in_ready", 32'(in_ready), 32'd1);
      @(posedge clock); #1;
      in_valid = 1'b0;
      check("tbl_lat1_invalid", 32'(out_valid), 32'd0);
      @(posedge clock); #1;
      check("tbl_lat2_valid", 32'(out_valid), 32'd1);
      check("tbl_sum", 32'(sum), 32'(tbl[i].exp_sum));
      @(posedge clock); #1;
      check("tbl_popped", 32'(out_valid), 32'd0);
      if (tbl[i].exp_sum[4]) n_carry++;
      if (i == 0) begin
        check("single_carry", 32'(carry_count), 32'd1);
        check("single_txn", 32'(txn_count), 32'd1);
      end
    end
    check("tbl_txn", 32'(txn_count), 32'd8);
    check("tbl_carry", 32'(carry_count), 32'(n_carry));

    // Back-to-back stream with no backpressure.
    reset_dut();
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 4'(i), 4'(15 - i), 1'b1);
      check("b2b_in_ready", 32'(in_ready), 32'd1);
      check("b2b_level_le1", 32'(fifo_level <= 3'd1), 32'd1);
      if (out_valid) check("b2b_sum", 32'(sum), 32'h0F);
    end
    drain();
    check("b2b_txn", 32'(txn_count), 32'd16);
    check("b2b_carry", 32'(carry_count), 32'd0);

    // Backpressure until full, then release.
    reset_dut();
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 4'h8, 4'h8, 1'b0);
      if (out_valid) check("bp_sum_hold", 32'(sum), 32'h10);
    end
    check("bp_accepts", 32'(acc_cnt), 32'd4);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_level", 32'(fifo_level), 32'd4);
    check("bp_txn", 32'(txn_count), 32'd4);
    drain();
    check("bp_carry", 32'(carry_count), 32'd4);
    check("bp_ready_back", 32'(in_ready), 32'd1);

    // Simultaneous push and pop at level 2 with s1 occupied.
    reset_dut();
    for (int i = 0; i < 3; i++) cycle(1'b1, 4'(i + 1), 4'(2 * i), 1'b0);
    check("pp_prefill_level", 32'(fifo_level), 32'd2);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 4'(3 * i), 4'(i + 5), 1'b1);
      check("pp_level", 32'(fifo_level), 32'd2);
    end
    drain();

    // Counter boundaries: txn wraps at 256, carry saturates at 8'hFF.
    reset_dut();
    for (int k = 0; k < 400 && acc_cnt < 256; k++) cycle(1'b1, 4'h8, 4'h8, 1'b1);
    check("wrap_accepts", 32'(acc_cnt), 32'd256);
    check("wrap_txn", 32'(txn_count), 32'd0);
    for (int k = 0; k < 100 && acc_cnt < 300; k++) cycle(1'b1, 4'h9, 4'hA, 1'b1);
    drain();
    check("sat_carry", 32'(carry_count), 32'hFF);
    check("sat_txn", 32'(txn_count), 32'd44);

    // Reset with three results buffered and s1 valid.
    reset_dut();
    for (int i = 0; i < 4; i++) cycle(1'b1, 4'h9, 4'h9, 1'b0);
    check("mid_level", 32'(fifo_level), 32'd3);
    check("mid_carry", 32'(carry_count), 32'd3);
    reset_dut();
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 4'h0, 4'h0, 1'b1);
      check("mid_no_stale", 32'(out_valid), 32'd0);
    end
    cycle(1'b1, 4'h3, 4'h4, 1'b1);
    drain();
    check("mid_resume_txn", 32'(txn_count), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
